// File: rtl/irq_controller.sv
// Interrupt controller: synchronises active-low sources, latches level/edge events,
// masks them and drives a registered active-low IRQ plus a priority vector.
module irq_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         ADDR,
  input  logic               CS,
  input  logic               WE,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  input  logic [NUM_SRC-1:0] src_n,
  output logic               IRQ
);

  typedef enum logic [1:0] {
    REG_PEND   = 2'd0,
    REG_MASK   = 2'd1,
    REG_MODE   = 2'd2,
    REG_VECTOR = 2'd3
  } reg_e;

  localparam logic [7:0] IMPL = 8'((16'd1 << NUM_SRC) - 16'd1);

  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_h;
  logic [7:0] r_pend;
  logic [7:0] r_mask;
  logic [7:0] r_mode;
  logic       r_irq;

  reg_e       w_addr;
  logic       w_wr;
  logic [7:0] w_src;
  logic [7:0] w_w1c;
  logic [7:0] w_fall;
  logic [7:0] w_pend_nxt;
  logic [7:0] w_active;
  logic [2:0] w_idx;
  logic       w_found;
  logic [7:0] w_vector;

  assign w_addr = reg_e'(ADDR);
  assign w_wr   = CS & WE;

  // Unimplemented source lines are held inactive so they never synchronise to an event.
  always_comb begin
    w_src = '1;
    w_src[NUM_SRC-1:0] = src_n;
  end

  assign w_w1c  = (w_wr && (w_addr == REG_PEND)) ? DI : '0;
  assign w_fall = r_h & ~r_s2;

  // Edge bits: a new edge wins over a same-cycle clear; level bits track the source.
  assign w_pend_nxt = ((r_mode & (w_fall | (r_pend & ~w_w1c))) | (~r_mode & ~r_s2)) & IMPL;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1   <= '1;
      r_s2   <= '1;
      r_h    <= '1;
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
      r_irq  <= 1'b1;
    end else begin
      r_s1   <= w_src;
      r_s2   <= r_s1;
      r_h    <= r_s2;
      r_pend <= w_pend_nxt;
      r_irq  <= ~|(r_pend & r_mask);
      if (w_wr && (w_addr == REG_MASK)) r_mask <= DI & IMPL;
      if (w_wr && (w_addr == REG_MODE)) r_mode <= DI & IMPL;
    end
  end

  assign w_active = r_pend & r_mask;

  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_found && w_active[i]) begin
        w_idx   = 3'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_vector = {|w_active, 4'b0000, w_idx};

  always_comb begin
    DO = '0;
    if (CS) begin
      unique case (w_addr)
        REG_PEND:   DO = r_pend;
        REG_MASK:   DO = r_mask;
        REG_MODE:   DO = r_mode;
        REG_VECTOR: DO = w_vector;
      endcase
    end
  end

  assign IRQ = r_irq;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: full-width instance plus a 2-source instance.
module tb_irq_controller;

  logic       clk;
  logic       resetn;
  logic [1:0] ADDR;
  logic       WE;
  logic [7:0] DI;
  logic       cs1, cs2;
  logic [7:0] do1, do2;
  logic [7:0] src_n1;
  logic [1:0] src_n2;
  logic       irq1, irq2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  rdata;

  irq_controller #(.NUM_SRC(8)) u_dut (
    .clk(clk), .resetn(resetn), .ADDR(ADDR), .CS(cs1), .WE(WE), .DI(DI),
    .DO(do1), .src_n(src_n1), .IRQ(irq1)
  );

  irq_controller #(.NUM_SRC(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .ADDR(ADDR), .CS(cs2), .WE(WE), .DI(DI),
    .DO(do2), .src_n(src_n2), .IRQ(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ADDR = a; DI = d; WE = 1'b1;
    if (sel) cs2 = 1'b1; else cs1 = 1'b1;
    @(negedge clk);
    WE = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, output logic [7:0] d);
    ADDR = a;
    if (sel) cs2 = 1'b1; else cs1 = 1'b1;
    #1;
    d = sel ? do2 : do1;
    cs1 = 1'b0; cs2 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; ADDR = '0; WE = 1'b0; DI = '0; cs1 = 1'b0; cs2 = 1'b0;
    src_n1 = 8'hFF; src_n2 = 2'b11;

    // 1: reset state
    cycles(3);
    check("t1_irq_in_reset", {7'd0, irq1}, 8'h01);
    resetn = 1'b1;
    cycles(3);
    check("t1_irq_after_reset", {7'd0, irq1}, 8'h01);
    rd(0, 2'd0, rdata); check("t1_pend", rdata, 8'h00);
    rd(0, 2'd1, rdata); check("t1_mask", rdata, 8'h00);
    rd(0, 2'd2, rdata); check("t1_mode", rdata, 8'h00);
    rd(0, 2'd3, rdata); check("t1_vector", rdata, 8'h00);
    check("t1_do_cs0", do1, 8'h00);

    // 2: level mode latency and release
    wr(0, 2'd1, 8'h03);
    wr(0, 2'd2, 8'h00);
    src_n1[1] = 1'b0;
    cycles(3);
    check("t2_irq_early", {7'd0, irq1}, 8'h01);
    cycles(1);
    check("t2_irq_k3", {7'd0, irq1}, 8'h00);
    rd(0, 2'd3, rdata); check("t2_vector", rdata, 8'h81);
    rd(0, 2'd0, rdata); check("t2_pend", rdata, 8'h02);
    wr(0, 2'd0, 8'h02);
    rd(0, 2'd0, rdata); check("t2_level_w1c_ignored", rdata, 8'h02);
    @(negedge clk);
    src_n1[1] = 1'b1;
    cycles(3);
    rd(0, 2'd0, rdata); check("t2_pend_release", rdata, 8'h00);
    check("t2_irq_still_low", {7'd0, irq1}, 8'h00);
    cycles(1);
    check("t2_irq_release", {7'd0, irq1}, 8'h01);

    // write with CS=0 is ignored
    @(negedge clk);
    ADDR = 2'd1; DI = 8'hA5; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
    rd(0, 2'd1, rdata); check("cs0_write_ignored", rdata, 8'h03);

    // 3: edge mode latch and W1C
    wr(0, 2'd2, 8'h01);
    wr(0, 2'd1, 8'h01);
    src_n1[0] = 1'b0;
    cycles(1);
    src_n1[0] = 1'b1;
    cycles(5);
    rd(0, 2'd0, rdata); check("t3_pend_latched", rdata, 8'h01);
    check("t3_irq_low", {7'd0, irq1}, 8'h00);
    wr(0, 2'd0, 8'h01);
    rd(0, 2'd0, rdata); check("t3_pend_cleared", rdata, 8'h00);
    check("t3_irq_hold", {7'd0, irq1}, 8'h00);
    cycles(1);
    check("t3_irq_high", {7'd0, irq1}, 8'h01);

    // 4: priority vector
    wr(0, 2'd2, 8'h05);
    wr(0, 2'd1, 8'h05);
    src_n1 = 8'hFA;
    cycles(1);
    src_n1 = 8'hFF;
    cycles(5);
    rd(0, 2'd0, rdata); check("t4_pend", rdata, 8'h05);
    rd(0, 2'd3, rdata); check("t4_vector_0", rdata, 8'h80);
    wr(0, 2'd0, 8'h01);
    rd(0, 2'd3, rdata); check("t4_vector_2", rdata, 8'h82);
    wr(0, 2'd0, 8'h04);
    rd(0, 2'd3, rdata); check("t4_vector_none", rdata, 8'h00);

    // 5: new edge coincides with W1C on an already pending bit
    wr(0, 2'd2, 8'h01);
    wr(0, 2'd1, 8'h01);
    src_n1[0] = 1'b0;
    cycles(1);
    src_n1[0] = 1'b1;
    cycles(5);
    rd(0, 2'd0, rdata); check("t5_pend_before", rdata, 8'h01);
    src_n1[0] = 1'b0;
    cycles(2);
    ADDR = 2'd0; DI = 8'h01; WE = 1'b1; cs1 = 1'b1;
    @(negedge clk);
    WE = 1'b0; cs1 = 1'b0;
    rd(0, 2'd0, rdata); check("t5_pend_kept", rdata, 8'h01);
    cycles(1);
    check("t5_irq_low", {7'd0, irq1}, 8'h00);
    wr(0, 2'd0, 8'h01);
    cycles(3);
    rd(0, 2'd0, rdata); check("t5_no_reset_held_low", rdata, 8'h00);
    src_n1[0] = 1'b1;

    // level-to-edge switch with source held low
    wr(0, 2'd1, 8'h00);
    wr(0, 2'd2, 8'h00);
    src_n1[3] = 1'b0;
    cycles(4);
    rd(0, 2'd0, rdata); check("l2e_pend_level", rdata, 8'h08);
    wr(0, 2'd2, 8'h08);
    cycles(2);
    rd(0, 2'd0, rdata); check("l2e_pend_kept", rdata, 8'h08);
    wr(0, 2'd0, 8'h08);
    cycles(3);
    rd(0, 2'd0, rdata); check("l2e_pend_cleared", rdata, 8'h00);
    check("l2e_irq_masked", {7'd0, irq1}, 8'h01);
    src_n1[3] = 1'b1;

    // 6: NUM_SRC=2 width rule and asynchronous reset
    wr(1, 2'd1, 8'hFF);
    rd(1, 2'd1, rdata); check("t6_mask_width", rdata, 8'h03);
    wr(1, 2'd2, 8'hFF);
    rd(1, 2'd2, rdata); check("t6_mode_width", rdata, 8'h03);
    wr(1, 2'd2, 8'h00);
    src_n2[0] = 1'b0;
    cycles(4);
    rd(1, 2'd0, rdata); check("t6_pend", rdata, 8'h01);
    check("t6_irq_low", {7'd0, irq2}, 8'h00);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_irq_async", {7'd0, irq2}, 8'h01);
    rd(1, 2'd0, rdata); check("t6_pend_async", rdata, 8'h00);
    rd(1, 2'd1, rdata); check("t6_mask_async", rdata, 8'h00);
    cycles(2);
    src_n2[0] = 1'b1;
    resetn = 1'b1;
    cycles(4);
    check("t6_irq_after", {7'd0, irq2}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
